// File: rtl/rv32_pkg.sv
// rv32_pkg: RV32I constants, opcode map, control-bundle layout and decode helpers
// shared by the decode stage and its immediate generator.
package rv32_pkg;

    localparam int XLEN    = 32;
    localparam int REGADDR = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Field order MSB first; downstream stages rely on this packing.
    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic alusrc;
        logic branch;
        logic jump;
    } ctrl_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    function automatic ctrl_t decode_ctrl(input logic [6:0] op);
        ctrl_t c;
        case (op)
            OP_R:      c = '{regwrite: 1'b1, default: 1'b0};
            OP_IMM:    c = '{regwrite: 1'b1, alusrc: 1'b1, default: 1'b0};
            OP_LOAD:   c = '{regwrite: 1'b1, memread: 1'b1, memtoreg: 1'b1, alusrc: 1'b1, default: 1'b0};
            OP_STORE:  c = '{memwrite: 1'b1, alusrc: 1'b1, default: 1'b0};
            OP_BRANCH: c = '{branch: 1'b1, default: 1'b0};
            OP_JAL:    c = '{regwrite: 1'b1, jump: 1'b1, default: 1'b0};
            OP_JALR:   c = '{regwrite: 1'b1, jump: 1'b1, alusrc: 1'b1, default: 1'b0};
            OP_LUI:    c = '{regwrite: 1'b1, alusrc: 1'b1, default: 1'b0};
            OP_AUIPC:  c = '{regwrite: 1'b1, alusrc: 1'b1, default: 1'b0};
            default:   c = '0;
        endcase
        return c;
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        return op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                          OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    endfunction

    function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
        imm_fmt_e f;
        case (op)
            OP_IMM, OP_LOAD, OP_JALR: f = IMM_I;
            OP_STORE:                 f = IMM_S;
            OP_BRANCH:                f = IMM_B;
            OP_LUI, OP_AUIPC:         f = IMM_U;
            OP_JAL:                   f = IMM_J;
            default:                  f = IMM_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational RV32I immediate extraction for the I/S/B/U/J formats,
// sign-extended from instr[31]; R-type and unknown opcodes yield 0.
module imm_gen #(
    parameter int XLEN = rv32_pkg::XLEN
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm
);
    import rv32_pkg::*;

    imm_fmt_e w_fmt;
    logic     w_s;

    assign w_fmt = imm_fmt(i_instr[6:0]);
    assign w_s   = i_instr[31];

    always_comb begin
        case (w_fmt)
            IMM_I:   o_imm = {{(XLEN-12){w_s}}, i_instr[31:20]};
            IMM_S:   o_imm = {{(XLEN-12){w_s}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   o_imm = {{(XLEN-12){w_s}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U:   o_imm = {{(XLEN-31){w_s}}, i_instr[30:12], 12'b0};
            IMM_J:   o_imm = {{(XLEN-20){w_s}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode with WB->ID bypass and load-use hazard detection,
// feeding the ID/EX pipeline register consumed by the EX stage.
module id_ex_stage #(
    parameter int XLEN    = rv32_pkg::XLEN,
    parameter int REGADDR = rv32_pkg::REGADDR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [31:0]        in_instr,
    input  logic [XLEN-1:0]    in_pc,
    output logic               in_ready,
    input  logic               flush,
    input  logic               ex_hold,
    output logic [REGADDR-1:0] rf_rs1,
    output logic [REGADDR-1:0] rf_rs2,
    input  logic [XLEN-1:0]    rf_rdata1,
    input  logic [XLEN-1:0]    rf_rdata2,
    input  logic               wb_regwrite,
    input  logic [REGADDR-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_op1,
    output logic [XLEN-1:0]    ex_op2,
    output logic [XLEN-1:0]    ex_imm,
    output logic [REGADDR-1:0] ex_rs1,
    output logic [REGADDR-1:0] ex_rs2,
    output logic [REGADDR-1:0] ex_rd,
    output logic [2:0]         ex_funct3,
    output logic               ex_funct7b5,
    output logic               ex_regwrite,
    output logic               ex_memread,
    output logic               ex_memwrite,
    output logic               ex_memtoreg,
    output logic               ex_alusrc,
    output logic               ex_branch,
    output logic               ex_jump,
    output logic               ex_illegal
);
    import rv32_pkg::*;

    logic [6:0]         w_opcode;
    logic [REGADDR-1:0] w_rs1;
    logic [REGADDR-1:0] w_rs2;
    logic [REGADDR-1:0] w_rd;
    ctrl_t              w_ctrl;
    logic               w_illegal;
    logic               w_uses_rs1;
    logic               w_uses_rs2;
    logic               w_hazard;
    logic [XLEN-1:0]    w_op1;
    logic [XLEN-1:0]    w_op2;
    logic [XLEN-1:0]    w_imm;

    logic               r_valid;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_op1;
    logic [XLEN-1:0]    r_op2;
    logic [XLEN-1:0]    r_imm;
    logic [REGADDR-1:0] r_rs1;
    logic [REGADDR-1:0] r_rs2;
    logic [REGADDR-1:0] r_rd;
    logic [2:0]         r_funct3;
    logic               r_funct7b5;
    ctrl_t              r_ctrl;
    logic               r_illegal;

    assign w_opcode  = in_instr[6:0];
    assign w_rs1     = in_instr[19:15];
    assign w_rs2     = in_instr[24:20];
    assign w_illegal = !is_legal(w_opcode);
    assign w_ctrl    = decode_ctrl(w_opcode);
    // A destination is only meaningful when the instruction writes back.
    assign w_rd      = w_ctrl.regwrite ? in_instr[11:7] : '0;

    assign rf_rs1 = w_rs1;
    assign rf_rs2 = w_rs2;

    assign w_uses_rs1 = !(w_opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
    assign w_uses_rs2 = w_opcode inside {OP_R, OP_STORE, OP_BRANCH};

    // The register file commits WB data on the same edge, so forward it here.
    assign w_op1 = (w_rs1 == '0) ? '0 :
                   (wb_regwrite && wb_rd == w_rs1) ? wb_data : rf_rdata1;
    assign w_op2 = (w_rs2 == '0) ? '0 :
                   (wb_regwrite && wb_rd == w_rs2) ? wb_data : rf_rdata2;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_instr (in_instr),
        .o_imm   (w_imm)
    );

    assign w_hazard = in_valid && r_valid && r_ctrl.memread && r_rd != '0 &&
                      ((r_rd == w_rs1 && w_uses_rs1) || (r_rd == w_rs2 && w_uses_rs2));

    assign in_ready = !w_hazard && !ex_hold;

    // Flush beats hold; the bubble drops memread, so a load-use stall is one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_funct3   <= '0;
            r_funct7b5 <= 1'b0;
            r_ctrl     <= '0;
            r_illegal  <= 1'b0;
        end else if (flush || (!ex_hold && w_hazard)) begin
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_illegal <= 1'b0;
            r_rd      <= '0;
        end else if (!ex_hold) begin
            r_valid    <= in_valid;
            r_pc       <= in_pc;
            r_op1      <= w_op1;
            r_op2      <= w_op2;
            r_imm      <= w_imm;
            r_rs1      <= w_rs1;
            r_rs2      <= w_rs2;
            r_rd       <= in_valid ? w_rd : '0;
            r_funct3   <= in_instr[14:12];
            r_funct7b5 <= in_instr[30];
            r_ctrl     <= in_valid ? w_ctrl : '0;
            r_illegal  <= in_valid && w_illegal;
        end
    end

    assign ex_valid    = r_valid;
    assign ex_pc       = r_pc;
    assign ex_op1      = r_op1;
    assign ex_op2      = r_op2;
    assign ex_imm      = r_imm;
    assign ex_rs1      = r_rs1;
    assign ex_rs2      = r_rs2;
    assign ex_rd       = r_rd;
    assign ex_funct3   = r_funct3;
    assign ex_funct7b5 = r_funct7b5;
    assign ex_regwrite = r_ctrl.regwrite;
    assign ex_memread  = r_ctrl.memread;
    assign ex_memwrite = r_ctrl.memwrite;
    assign ex_memtoreg = r_ctrl.memtoreg;
    assign ex_alusrc   = r_ctrl.alusrc;
    assign ex_branch   = r_ctrl.branch;
    assign ex_jump     = r_ctrl.jump;
    assign ex_illegal  = r_illegal;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Instruction-decode stage plus ID/EX pipeline register for the RV32I pipeline.
- Sits directly upstream of the register file's consumers and drives the register-file read addresses.
- Takes the IF/ID instruction, reads operands from the register file, bypasses same-cycle writeback data, and detects load-use hazards.
- Registers the decoded bundle for the EX stage.

Parameters:
- XLEN, 32, datapath and PC width.
- REGADDR, 5, register address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  IF/ID holds a valid instruction.
- in_instr  in  32  IF/ID instruction.
- in_pc  in  XLEN  IF/ID PC.
- in_ready  out  1  stage accepts the IF/ID word this cycle (0 = stall fetch).
- flush  in  1  kill the instruction being captured (branch taken in EX).
- ex_hold  in  1  downstream stall; ID/EX register keeps its value.
- rf_rs1, rf_rs2  out  REGADDR  register-file read addresses.
- rf_rdata1, rf_rdata2  in  XLEN  register-file read data.
- wb_regwrite  in  1  writeback write enable.
- wb_rd  in  REGADDR  writeback destination.
- wb_data  in  XLEN  writeback data.
- ex_valid  out  1  ID/EX contents valid.
- ex_pc  out  XLEN  registered PC.
- ex_op1, ex_op2  out  XLEN  registered rs1/rs2 operand values.
- ex_imm  out  XLEN  sign-extended immediate.
- ex_rs1, ex_rs2, ex_rd  out  REGADDR  registered register indices.
- ex_funct3  out  3  registered funct3.
- ex_funct7b5  out  1  registered instr[30].
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_branch, ex_jump  out  1 each  control bits.
- ex_illegal  out  1  unknown opcode captured.

Behaviour:
- Reset (async, rst_n=0): every ex_* output is 0; in_ready reflects combinational logic only.
- Read addresses: rf_rs1 = in_instr[19:15] and rf_rs2 = in_instr[24:20], combinational. The register file reads combinationally, so latency is 0 to the operand mux and 1 clk to the ex_* outputs.
- Operand selection, in priority order:
  - index 0 forces 0;
  - else, if wb_regwrite && wb_rd==index, take wb_data (WB→ID bypass; the register file writes on the same edge);
  - else take rf_rdata.
- Opcode decode:
  - R 0110011: regwrite.
  - I-ALU 0010011: regwrite, alusrc.
  - LOAD 0000011: regwrite, memread, memtoreg, alusrc.
  - STORE 0100011: memwrite, alusrc.
  - BRANCH 1100011: branch.
  - JAL 1101111: regwrite, jump.
  - JALR 1100111: regwrite, jump, alusrc.
  - LUI 0110111: regwrite, alusrc.
  - AUIPC 0010111: regwrite, alusrc.
- Immediate formats: I, S, B (bit0=0), U (low 12 bits=0), J (bit0=0), all sign-extended from instr[31]. R-type imm = 0.
- Unused-source rules:
  - uses_rs1 = not (LUI, AUIPC, JAL).
  - uses_rs2 = R, STORE, BRANCH.
  - ex_rd forced 0 when regwrite=0.
- Illegal opcode: captured with ex_valid=1, ex_illegal=1, all control bits 0.
- Load-use hazard = in_valid && ex_valid && ex_memread && ex_rd!=0 && ((ex_rd==rs1 && uses_rs1) || (ex_rd==rs2 && uses_rs2)).
- in_ready = !hazard && !ex_hold.
- Clock-edge priority (highest first):
  1. flush → ex_valid=0, all controls 0.
  2. ex_hold → all ex_* held.
  3. hazard → bubble (ex_valid=0, controls 0).
  4. Otherwise → capture; ex_valid=in_valid, and controls are zeroed when in_valid=0.
- Flush concurrent with hazard or hold: flush wins; the bubble still clears the hazard next cycle.
- Stall duration: a load-use stall lasts exactly 1 cycle, because the bubble clears ex_memread.

Decomposition:
- Shared package `rv32_pkg`:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - XLEN/REGADDR constants;
  - control-bundle field order.
- One sub-module, `imm_gen`: combinational instr→imm for the five formats.
- The rest (decode, bypass, hazard, register) stays inline.

Test Plan:
- Reset, then `addi x1,x0,5` (0x00500093) valid → next cycle ex_valid=1, ex_rd=1, ex_imm=5, ex_regwrite=1, ex_alusrc=1, ex_op1=0.
- `add x3,x1,x2` with rf_rdata1=7, and wb_regwrite=1, wb_rd=2, wb_data=9 (rf_rdata2=0) → ex_op1=7, ex_op2=9 (bypass). Repeat with wb_rd=0 → ex_op2=rf_rdata2.
- `lw x5,0(x1)` captured, then `add x6,x5,x4` → in_ready=0 for 1 cycle, ex_valid=0 bubble, then add captured. Same sequence with `lui x6` → no stall.
- flush=1 together with a valid instruction, and separately with ex_hold=1 → ex_valid=0 next cycle.
- ex_hold=1 for 3 cycles → ex_* unchanged and in_ready=0. Release → next instruction captured.
- Immediate checks:
  - `sw x2,-4(x1)` → ex_imm=0xFFFFFFFC, ex_memwrite=1, ex_rd=0.
  - `beq` offset −8 → 0xFFFFFFF8.
  - `jal` +2048 → 0x00000800.
  - opcode 0x7F → ex_illegal=1, controls 0.
  - async reset asserted mid-stream → all ex_* are 0 immediately.
